// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: decides on (re)allocation per resolved branch,
// queues allocations in a small FIFO and drains one per cycle into the BTB.
module btb_update_ctrl #(
  parameter int INDEX_WIDTH = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ex_valid_i,
  output logic                        ex_ready_o,
  input  logic [31:0]                 ex_pc_i,
  input  logic [31:0]                 ex_target_i,
  input  logic                        ex_taken_i,
  input  logic                        ex_pred_taken_i,
  input  logic                        ex_btb_hit_i,
  input  logic [31:0]                 ex_btb_target_i,
  input  logic                        ex_btb_bias_i,
  input  logic                        wr_ready_i,
  output logic                        wren_o,
  output logic [INDEX_WIDTH-1:0]      wr_index_o,
  output logic [32-INDEX_WIDTH-3:0]   wr_tag_o,
  output logic [31:0]                 wr_target_o,
  output logic                        br_taken_o,
  output logic                        pht_upd_o,
  output logic                        pht_agree_o,
  output logic [31:0]                 pht_pc_o,
  output logic                        mispredict_o,
  output logic [$clog2(FIFO_DEPTH):0] occ_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = 32 - INDEX_WIDTH - 2;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [TW-1:0]          tag;
    logic [31:0]            target;
    logic                   bias;
  } alloc_t;

  alloc_t      r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_mispredict, r_pht_upd, r_pht_agree;
  logic [31:0] r_pht_pc;

  logic   w_tgt_mis, w_alloc, w_full, w_empty, w_accept, w_push, w_pop;
  alloc_t w_new, w_head;

  assign w_tgt_mis = ex_taken_i & (ex_btb_target_i != ex_target_i);
  assign w_alloc   = ~ex_btb_hit_i | w_tgt_mis;
  // Extra wrap bit distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Non-allocating branches never stall; ready ignores the drain side.
  assign ex_ready_o = ~w_full | ~w_alloc;
  assign w_accept   = ex_valid_i & ex_ready_o;
  assign w_push     = w_accept & w_alloc;
  assign wren_o     = ~w_empty & wr_ready_i;
  assign w_pop      = wren_o;

  always_comb begin
    w_new        = '0;
    w_new.index  = ex_pc_i[INDEX_WIDTH+1:2];
    w_new.tag    = ex_pc_i[31:INDEX_WIDTH+2];
    w_new.target = ex_target_i;
    // A miss seeds the bias with the first outcome; a hit keeps the old bias.
    w_new.bias   = ex_btb_hit_i ? ex_btb_bias_i : ex_taken_i;
  end

  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign wr_index_o  = w_head.index;
  assign wr_tag_o    = w_head.tag;
  assign wr_target_o = w_head.target;
  assign br_taken_o  = w_head.bias;
  assign occ_o       = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_new;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mispredict <= 1'b0;
      r_pht_upd    <= 1'b0;
      r_pht_agree  <= 1'b0;
      r_pht_pc     <= '0;
    end else begin
      r_mispredict <= w_accept & ((ex_pred_taken_i != ex_taken_i) | w_tgt_mis);
      r_pht_upd    <= w_accept & ex_btb_hit_i;
      r_pht_agree  <= w_accept & ex_btb_hit_i & (ex_taken_i == ex_btb_bias_i);
      if (w_accept & ex_btb_hit_i) r_pht_pc <= ex_pc_i;
    end
  end

  assign mispredict_o = r_mispredict;
  assign pht_upd_o    = r_pht_upd;
  assign pht_agree_o  = r_pht_agree;
  assign pht_pc_o     = r_pht_pc;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed test-plan steps plus random traffic
// checked against a queue-based reference model.
module tb_btb_update_ctrl;
  localparam int IW = 6;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_valid_i = 1'b0, ex_ready_o;
  logic [31:0] ex_pc_i = '0, ex_target_i = '0, ex_btb_target_i = '0;
  logic        ex_taken_i = 1'b0, ex_pred_taken_i = 1'b0, ex_btb_hit_i = 1'b0, ex_btb_bias_i = 1'b0;
  logic        wr_ready_i = 1'b0, wren_o;
  logic [IW-1:0] wr_index_o;
  logic [32-IW-3:0] wr_tag_o;
  logic [31:0] wr_target_o, pht_pc_o;
  logic        br_taken_o, pht_upd_o, pht_agree_o, mispredict_o;
  logic [$clog2(DEPTH):0] occ_o;

  btb_update_ctrl #(.INDEX_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i),
    .ex_taken_i(ex_taken_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_btb_hit_i(ex_btb_hit_i), .ex_btb_target_i(ex_btb_target_i),
    .ex_btb_bias_i(ex_btb_bias_i), .wr_ready_i(wr_ready_i),
    .wren_o(wren_o), .wr_index_o(wr_index_o), .wr_tag_o(wr_tag_o),
    .wr_target_o(wr_target_o), .br_taken_o(br_taken_o),
    .pht_upd_o(pht_upd_o), .pht_agree_o(pht_agree_o), .pht_pc_o(pht_pc_o),
    .mispredict_o(mispredict_o), .occ_o(occ_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] tag;
    logic [31:0] tgt;
    logic        bias;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One cycle: drive EX/drain inputs, check combinational outputs against the
  // model, clock, then check the registered pulses for this cycle's branch.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic tk, input logic pr, input logic hit,
                      input logic [31:0] btgt, input logic bias, input logic wrdy);
    logic alloc, ready, acc, wr;
    ent_t e;
    ex_valid_i = v; ex_pc_i = pc; ex_target_i = tgt; ex_taken_i = tk;
    ex_pred_taken_i = pr; ex_btb_hit_i = hit; ex_btb_target_i = btgt;
    ex_btb_bias_i = bias; wr_ready_i = wrdy;
    #1;
    alloc = !hit || (tk && btgt != tgt);
    ready = (q.size() < DEPTH) || !alloc;
    acc   = v && ready;
    wr    = (q.size() > 0) && wrdy;
    chk("ex_ready", 32'(ex_ready_o), 32'(ready));
    chk("occ", 32'(occ_o), 32'(q.size()));
    chk("wren", 32'(wren_o), 32'(wr));
    if (q.size() > 0) begin
      chk("wr_index", 32'(wr_index_o), q[0].idx);
      chk("wr_tag", 32'(wr_tag_o), q[0].tag);
      chk("wr_target", wr_target_o, q[0].tgt);
      chk("br_taken", 32'(br_taken_o), 32'(q[0].bias));
    end
    @(posedge clk_i); #1;
    if (wr) void'(q.pop_front());
    if (acc && alloc) begin
      e.idx  = (pc / 4) % 64;
      e.tag  = pc / 256;
      e.tgt  = tgt;
      e.bias = hit ? bias : tk;
      q.push_back(e);
    end
    chk("mispredict", 32'(mispredict_o), 32'(acc && ((pr != tk) || (tk && btgt != tgt))));
    chk("pht_upd", 32'(pht_upd_o), 32'(acc && hit));
    if (acc && hit) begin
      chk("pht_agree", 32'(pht_agree_o), 32'(tk == bias));
      chk("pht_pc", pht_pc_o, pc);
    end
    ex_valid_i = 1'b0;
  endtask

  task automatic miss(input logic [31:0] pc, input logic wrdy);
    step(1'b1, pc, pc + 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, wrdy);
  endtask

  task automatic idle(input logic wrdy);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, wrdy);
  endtask

  initial begin
    logic [31:0] pc, tgt;
    // Reset state
    wr_ready_i = 1'b1;
    #2;
    chk("rst_occ", 32'(occ_o), 32'h0);
    chk("rst_wren", 32'(wren_o), 32'h0);
    chk("rst_pht_upd", 32'(pht_upd_o), 32'h0);
    chk("rst_pht_agree", 32'(pht_agree_o), 32'h0);
    chk("rst_pht_pc", pht_pc_o, 32'h0);
    chk("rst_mispredict", 32'(mispredict_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Miss not taken, then its write next cycle
    step(1'b1, 32'h100, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("plan_idx", 32'(wr_index_o), 32'h0);
    chk("plan_tag", 32'(wr_tag_o), 32'h1);
    idle(1'b1);
    // Hit, taken, target match: no enqueue, agree update
    step(1'b1, 32'h204, 32'h300, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
    idle(1'b1);
    // Hit, taken, target mismatch: reallocate keeping bias 0
    step(1'b1, 32'h208, 32'h380, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Stall: five misses with the write port busy, then a non-allocating hit
    for (int i = 0; i < 5; i++) miss(32'h1000 + 32'(i) * 32'h104, 1'b0);
    step(1'b1, 32'h2000, 32'h2100, 1'b1, 1'b1, 1'b1, 32'h2100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Full queue with the port free: refused, popped, then accepted
    for (int i = 0; i < 4; i++) miss(32'h3000 + 32'(i) * 32'h4, 1'b0);
    miss(32'h3ff0, 1'b1);
    miss(32'h3ff0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pc  = $urandom() & 32'hffff_fffc;
      tgt = $urandom() & 32'hffff_fffc;
      step(1'($urandom_range(0, 3) != 0), pc, tgt, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0) ? tgt : ($urandom() & 32'hffff_fffc),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset mid-operation: three queued, pending mispredict pulse
    miss(32'h500, 1'b0);
    miss(32'h504, 1'b0);
    step(1'b1, 32'h508, 32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    wr_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    q.delete();
    chk("midrst_occ", 32'(occ_o), 32'h0);
    chk("midrst_wren", 32'(wren_o), 32'h0);
    chk("midrst_mispredict", 32'(mispredict_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(1'b1);
    miss(32'h700, 1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
